// File: rtl/freq_gate_ctrl.sv
//============================================================================
// Module  : freq_gate_ctrl
// Brief   : Gate/settle/latch sequencer driving the BCD frequency counter's
//           ENA/CLR and holding the last completed result for the display.
//           Optional macro FREQ_OVF_DETECT_EN builds the saturation/invalid
//           BCD flag on ovf; without it ovf is tied low.
// Revision: 1.0  initial release
//============================================================================
`default_nettype none

module freq_gate_ctrl #(
  parameter int GATE_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [23:0] q_in,
  output logic        ena,
  output logic        clr_cnt,
  output logic        load,
  output logic [23:0] q_out,
  output logic        valid,
  output logic        ovf
);

  localparam logic [15:0] c_gate_last   = 16'(GATE_CYCLES - 1);
  localparam logic [15:0] c_settle_last = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LOAD   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_ena;
  logic        r_clr;
  logic        r_load;
  logic        r_valid;
  logic [23:0] r_q_out;

  // Dropping run anywhere before LOAD abandons the window; LOAD always completes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = run ? S_GATE : S_IDLE;
      end
      S_GATE: begin
        if (!run)                     w_state_nxt = S_IDLE;
        else if (r_cnt == c_gate_last) w_state_nxt = S_SETTLE;
        else                           w_cnt_nxt   = r_cnt + 16'd1;
      end
      S_SETTLE: begin
        if (!run)                       w_state_nxt = S_IDLE;
        else if (r_cnt == c_settle_last) w_state_nxt = S_LOAD;
        else                             w_cnt_nxt   = r_cnt + 16'd1;
      end
      S_LOAD: begin
        w_state_nxt = run ? S_CLEAR : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes are registered decodes of the next state, so they align with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ena   <= 1'b0;
      r_clr   <= 1'b0;
      r_load  <= 1'b0;
      r_valid <= 1'b0;
      r_q_out <= 24'h000000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ena   <= (w_state_nxt == S_GATE);
      r_clr   <= (w_state_nxt == S_CLEAR);
      r_load  <= (w_state_nxt == S_LOAD);
      r_valid <= (r_state == S_LOAD);
      if (r_state == S_LOAD) r_q_out <= q_in;
    end
  end

  assign ena     = r_ena;
  assign clr_cnt = r_clr;
  assign load    = r_load;
  assign valid   = r_valid;
  assign q_out   = r_q_out;

`ifdef FREQ_OVF_DETECT_EN
  logic [5:0] w_nib_bad;
  logic       w_ovf_nxt;
  logic       r_ovf;

  for (genvar gi = 0; gi < 6; gi++) begin : g_nib
    assign w_nib_bad[gi] = (q_in[gi*4 +: 4] > 4'd9);
  end

  // 999999 means the counter saturated during the window.
  assign w_ovf_nxt = (q_in == 24'h999999) || (|w_nib_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
//============================================================================
// Module  : tb_freq_gate_ctrl
// Brief   : Bench for freq_gate_ctrl: two instances (8/2 and 2/1) against a
//           measurement-position model. Honours FREQ_OVF_DETECT_EN.
// Revision: 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_freq_gate_ctrl;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [23:0] q_in_v [N];
  wire         ena_v [N];
  wire         clr_v [N];
  wire         load_v [N];
  wire  [23:0] q_out_v [N];
  wire         valid_v [N];
  wire         ovf_v [N];

  int          checks = 0;
  int          errors = 0;
  int          q_mode = 0;
  logic [23:0] q_fix = 24'h0;
  logic [23:0] bcd_cnt [N];

  // Measurement model: position 0 = clear cycle, 1..G gate, then settle, last = load.
  bit          m_busy [N];
  int          m_pos [N];
  logic [23:0] m_qout [N];
  bit          m_valid [N];
  bit          m_ovf [N];

  int          excl_bad = 0;
  int          rise_bad = 0;
  bit          ena_prev [N];
  bit          clr_prev [N];

  always #5 clk = ~clk;

  freq_gate_ctrl #(.GATE_CYCLES(8), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .q_in(q_in_v[0]),
    .ena(ena_v[0]), .clr_cnt(clr_v[0]), .load(load_v[0]),
    .q_out(q_out_v[0]), .valid(valid_v[0]), .ovf(ovf_v[0])
  );

  freq_gate_ctrl #(.GATE_CYCLES(2), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .q_in(q_in_v[1]),
    .ena(ena_v[1]), .clr_cnt(clr_v[1]), .load(load_v[1]),
    .q_out(q_out_v[1]), .valid(valid_v[1]), .ovf(ovf_v[1])
  );

  function automatic int gc(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic int sc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int per(input int k);
    return gc(k) + sc(k) + 2;
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    bit c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic bit exp_ovf(input logic [23:0] q);
    bit bad;
    bad = (q == 24'h999999);
    for (int i = 0; i < 6; i++) if (q[i*4 +: 4] > 4'd9) bad = 1'b1;
`ifdef FREQ_OVF_DETECT_EN
    return bad;
`else
    return bad & 1'b0;
`endif
  endfunction

  function automatic logic [23:0] rand_q();
    logic [23:0] r;
    r = 24'h0;
    if ($urandom_range(0, 9) == 0) r = 24'h999999;
    else if ($urandom_range(0, 1) == 0) begin
      for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    end else r = 24'($urandom());
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Emulates the F_IN counter: cleared by clr_cnt, +1 BCD per ena cycle.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n)          bcd_cnt[k] <= 24'h0;
      else if (clr_v[k])   bcd_cnt[k] <= 24'h0;
      else if (ena_v[k])   bcd_cnt[k] <= bcd_inc(bcd_cnt[k]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      case (q_mode)
        0:       q_in_v[k] = bcd_cnt[k];
        1:       q_in_v[k] = rand_q();
        default: q_in_v[k] = q_fix;
      endcase
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        m_busy[k]  <= 1'b0;
        m_pos[k]   <= 0;
        m_qout[k]  <= 24'h0;
        m_valid[k] <= 1'b0;
        m_ovf[k]   <= 1'b0;
      end else begin
        if (m_busy[k] && m_pos[k] == per(k) - 1) begin
          m_qout[k]  <= q_in_v[k];
          m_valid[k] <= 1'b1;
          m_ovf[k]   <= exp_ovf(q_in_v[k]);
        end else m_valid[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (run) begin
            m_busy[k] <= 1'b1;
            m_pos[k]  <= 0;
          end
        end else if (m_pos[k] == per(k) - 1) begin
          if (run) m_pos[k] <= 0;
          else     m_busy[k] <= 1'b0;
        end else if (!run) m_busy[k] <= 1'b0;
        else m_pos[k] <= m_pos[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("u%0d.ena", k), 32'(ena_v[k]),
          32'(m_busy[k] && m_pos[k] >= 1 && m_pos[k] <= gc(k)));
      chk($sformatf("u%0d.clr_cnt", k), 32'(clr_v[k]), 32'(m_busy[k] && m_pos[k] == 0));
      chk($sformatf("u%0d.load", k), 32'(load_v[k]),
          32'(m_busy[k] && m_pos[k] == per(k) - 1));
      chk($sformatf("u%0d.valid", k), 32'(valid_v[k]), 32'(m_valid[k]));
      chk($sformatf("u%0d.q_out", k), 32'(q_out_v[k]), 32'(m_qout[k]));
      chk($sformatf("u%0d.ovf", k), 32'(ovf_v[k]), 32'(m_ovf[k]));
      if (ena_v[k] && clr_v[k]) excl_bad <= excl_bad + 1;
      if (ena_v[k] && !ena_prev[k] && !clr_prev[k]) rise_bad <= rise_bad + 1;
      ena_prev[k] <= ena_v[k];
      clr_prev[k] <= clr_v[k];
    end
  end

  task automatic measure(input int k, output int cyc, output int enas, output bit ok);
    cyc  = 0;
    enas = 0;
    ok   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (ena_v[k]) enas++;
      if (valid_v[k]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          en;
    bit          ok;
    logic [23:0] ovf_vals [3];
    bit          ovf_exp [3];
    ovf_vals = '{24'h999999, 24'h00000A, 24'h123456};
`ifdef FREQ_OVF_DETECT_EN
    ovf_exp = '{1'b1, 1'b1, 1'b0};
`else
    ovf_exp = '{1'b0, 1'b0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("reset_ena", 32'(ena_v[0]), 32'd0);
    chk("reset_clr", 32'(clr_v[0]), 32'd0);
    chk("reset_valid", 32'(valid_v[0]), 32'd0);
    chk("reset_q_out", 32'(q_out_v[0]), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run = 1'b1;

    measure(0, cyc, en, ok);
    chk("first_valid_seen", 32'(ok), 32'd1);
    chk("first_latency", 32'(cyc), 32'd13);
    chk("first_ena_len", 32'(en), 32'd8);
    chk("first_q_out", 32'(q_out_v[0]), 32'h000008);
    chk("model_q_out", 32'(m_qout[0]), 32'h000008);
    chk("first_ovf", 32'(ovf_v[0]), 32'd0);
    measure(0, cyc, en, ok);
    chk("period_default", 32'(cyc), 32'd12);
    chk("ena_len_default", 32'(en), 32'd8);
    measure(1, cyc, en, ok);
    measure(1, cyc, en, ok);
    chk("period_small", 32'(cyc), 32'd5);
    chk("ena_len_small", 32'(en), 32'd2);

    // Abort in the 4th gate cycle of the default instance.
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (clr_v[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_find_clr", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    chk("gate4_ena", 32'(ena_v[0]), 32'd1);
    run = 1'b0;
    @(negedge clk);
    chk("abort_ena_low", 32'(ena_v[0]), 32'd0);
    en = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid_v[0]) en++;
    end
    chk("abort_no_valid", 32'(en), 32'd0);
    chk("abort_hold_q", 32'(q_out_v[0]), 32'h000008);
    run = 1'b1;
    @(negedge clk);
    chk("restart_clr", 32'(clr_v[0]), 32'd1);
    chk("restart_ena", 32'(ena_v[0]), 32'd0);
    @(negedge clk);
    chk("restart_gate", 32'(ena_v[0]), 32'd1);

    // Asynchronous reset during SETTLE.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ena_v[0]) break;
    end
    chk("settle_reached", 32'(ena_v[0]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ena", 32'(ena_v[0]), 32'd0);
    chk("rst_mid_load", 32'(load_v[0]), 32'd0);
    chk("rst_mid_valid", 32'(valid_v[0]), 32'd0);
    chk("rst_mid_q_out", 32'(q_out_v[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(0, cyc, en, ok);
    chk("rerun_latency", 32'(cyc), 32'd13);
    chk("rerun_ena_len", 32'(en), 32'd8);
    chk("rerun_q_out", 32'(q_out_v[0]), 32'h000008);

    q_mode = 2;
    for (int v = 0; v < 3; v++) begin
      q_fix = ovf_vals[v];
      measure(0, cyc, en, ok);
      measure(0, cyc, en, ok);
      chk($sformatf("ovf_q_out_%0d", v), 32'(q_out_v[0]), 32'(ovf_vals[v]));
      chk($sformatf("ovf_flag_%0d", v), 32'(ovf_v[0]), 32'(ovf_exp[v]));
    end

    q_mode = 1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) run = ~run;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk("ena_clr_overlap", 32'(excl_bad), 32'd0);
    chk("ena_rise_without_clr", 32'(rise_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Timing/control stage directly upstream of the 24-bit BCD frequency counter. It drives that counter's ENA and CLR inputs.
- Runs on a stable reference clock and opens a gate window of a fixed number of reference cycles.
- After each window it lets the counter settle, then latches the counter's Q into a held display register and pulses VALID.
- The display/scan stage downstream reads only the held register.

Parameters:
- GATE_CYCLES, 8: reference-clock cycles the gate (ENA) is high per measurement; legal range 2..65535.
- SETTLE_CYCLES, 2: cycles with ENA low before latching, so the asynchronous F_IN-clocked counter settles; legal range 1..15.

Ports:
- CLK  input  1  reference clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RUN  input  1  1 = measure continuously; 0 = stop after abort/idle.
- Q_IN  input  24  BCD count from the frequency counter (6 digits, digit 0 = bits 3:0).
- ENA  output  1  gate enable to the counter.
- CLR_CNT  output  1  active-high clear to the counter.
- LOAD  output  1  one-cycle strobe, high in the cycle Q_IN is sampled.
- Q_OUT  output  24  held BCD result of the last completed measurement.
- VALID  output  1  one-cycle pulse: Q_OUT updated this cycle.
- OVF  output  1  overflow flag for Q_OUT (see Optional Feature).

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; ENA=0, CLR_CNT=0, LOAD=0, Q_OUT=24'h000000, VALID=0, OVF=0; gate/settle counter=0.
- All outputs are registered and Moore-decoded from the state register. No combinational path from RUN or Q_IN to any output.
- States and transitions:
  - IDLE: all strobes low. If RUN=1, go to CLEAR next edge.
  - CLEAR: exactly 1 cycle, CLR_CNT=1, ENA=0. Then GATE with the counter loaded to 0.
  - GATE: ENA=1 for exactly GATE_CYCLES consecutive cycles. Counter increments each cycle; at GATE_CYCLES-1 go to SETTLE.
  - SETTLE: ENA=0 for exactly SETTLE_CYCLES cycles. Then go to LOAD.
  - LOAD: LOAD=1 for 1 cycle. On the edge leaving LOAD: Q_OUT<=Q_IN, VALID<=1 for one cycle, OVF updated. Next state is CLEAR if RUN=1, else IDLE.
- Measurement period (continuous): GATE_CYCLES+SETTLE_CYCLES+2 cycles. Defaults give 12, with VALID once per 12 cycles.
- ENA and CLR_CNT are never high in the same cycle. ENA never rises without a CLR_CNT pulse in the preceding cycle.
- RUN deasserted in CLEAR, GATE or SETTLE: abort.
  - Next state is IDLE; ENA drops next edge.
  - No LOAD or VALID. Q_OUT/OVF retain the previous result.
- RUN deasserted during LOAD: the load completes normally, then IDLE.
- RUN re-asserted in IDLE always starts a fresh CLEAR; a partial window is never resumed.
- Reset mid-measurement: immediate return to reset values, including Q_OUT cleared.
- Q_IN is not interpreted except by OVF logic. It is passed through bit-exact.

Optional Feature:
- Macro: FREQ_OVF_DETECT_EN.
- When defined, OVF is registered with Q_OUT at load time. OVF=1 if Q_IN==24'h999999 (counter saturated) or any nibble of Q_IN >4'h9 (invalid BCD); otherwise 0. OVF holds until the next load or reset.
- When not defined, OVF is constant 0 and no comparison logic is built.

Test Plan:
- Reset then RUN=1, defaults: CLR_CNT high 1 cycle, ENA high exactly 8 cycles, 2 low, LOAD 1 cycle. VALID next cycle; repeat period 12 cycles.
- Bench model of counter increments BCD each ENA cycle: Q_IN=24'h000008 at LOAD → Q_OUT=24'h000008, VALID=1 one cycle, OVF=0.
- RUN dropped in the 4th GATE cycle: ENA low next edge, state IDLE, no VALID, Q_OUT keeps 24'h000008. Re-raising RUN gives a CLR_CNT pulse first.
- RST_N pulsed low during SETTLE: all outputs 0 immediately, Q_OUT=24'h000000. Restart on RUN behaves as the first scenario.
- FREQ_OVF_DETECT_EN defined: Q_IN=24'h999999 at load → OVF=1. Q_IN=24'h00000A → OVF=1. Q_IN=24'h123456 → OVF=0. Macro undefined: OVF=0 in all three cases.
- GATE_CYCLES=2, SETTLE_CYCLES=1: ENA high 2 cycles, period 5 cycles. Assert ENA&CLR_CNT never 1 together over 100 cycles.
